// File: rtl/spi_peripheral_cs.sv
// -----------------------------------------------------------------------------
// spi_peripheral_cs
//   SPI peripheral (slave) endpoint for a CS-framed SPI master. SCK, CS_L and
//   MOSI are brought into the clk domain through 2-FF synchronizers, and all
//   edge detection runs on the synchronized copies. clk must run at least
//   4x SCK.
//
//   Build option: define SPI_PERIPH_TRISTATE_EN to release MISO (1'bz)
//   whenever synced CS_L is high or no frame is active, for a shared MISO bus.
//   Without it, MISO is driven 0 outside an active frame.
//
// Parameters
//   SPI_MODE         CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//   MAX_BYTES_PER_CS bytes expected per CS_L low period (overflow threshold)
//   UNDERRUN_BYTE    byte shifted out when the TX holding register is empty
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   SCK, CS_L     SPI clock and active-low chip select from master (async)
//   MOSI, MISO    serial data in from / out to master
//   o_MOSI_Byte   received byte, valid with o_MOSI_DV (1-clk pulse)
//   o_MOSI_Count  0-based index of o_MOSI_Byte within the frame
//   i_MISO_Byte   next byte to transmit, loaded by i_MISO_DV while
//                 o_MISO_Ready (holding register empty) is high
//   o_Frame_Done  1-clk pulse when CS_L rises at the end of a frame
//   o_Overflow    sticky, more than MAX_BYTES_PER_CS bytes this frame
//   o_Underrun    sticky, UNDERRUN_BYTE was sent this frame
// -----------------------------------------------------------------------------
module spi_peripheral_cs #(
  parameter int unsigned SPI_MODE         = 0,
  parameter int unsigned MAX_BYTES_PER_CS = 2,
  parameter logic [7:0]  UNDERRUN_BYTE    = 8'hFF,
  localparam int unsigned CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCK,
  input  logic          CS_L,
  input  logic          MOSI,
  output logic          MISO,
  output logic [7:0]    o_MOSI_Byte,
  output logic          o_MOSI_DV,
  output logic [CW-1:0] o_MOSI_Count,
  input  logic [7:0]    i_MISO_Byte,
  input  logic          i_MISO_DV,
  output logic          o_MISO_Ready,
  output logic          o_Frame_Done,
  output logic          o_Overflow,
  output logic          o_Underrun
);

  localparam logic CPOL = (SPI_MODE & 32'd2) != 0;
  localparam logic CPHA = (SPI_MODE & 32'd1) != 0;
  localparam logic [CW-1:0] MAX_IDX = CW'(MAX_BYTES_PER_CS);

  localparam logic [1:0] ST_WAIT_HIGH = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronizers, bit order {MOSI, CS_L, SCK}
  // ---------------------------------------------------------------------------
  localparam logic [2:0] SYNC_RST = {1'b0, 1'b1, CPOL};

  logic [2:0] pins_raw;
  logic [2:0] pins_sync;
  assign pins_raw = {MOSI, CS_L, SCK};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= SYNC_RST[gi];
        sync_q <= SYNC_RST[gi];
      end else begin
        meta_q <= pins_raw[gi];
        sync_q <= meta_q;
      end
    end
    assign pins_sync[gi] = sync_q;
  end

  logic sck_s, cs_s, mosi_s;
  assign sck_s  = pins_sync[0];
  assign cs_s   = pins_sync[1];
  assign mosi_s = pins_sync[2];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q,    state_d;
  logic          sck_prev_q, cs_prev_q;
  logic [1:0]    flush_q;
  logic [2:0]    bit_cnt_q,  bit_cnt_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    rx_q,       rx_d;
  logic [7:0]    tx_q,       tx_d;
  logic [2:0]    tx_cnt_q,   tx_cnt_d;
  logic          first_q,    first_d;
  logic [7:0]    hold_q,     hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    byte_q,     byte_d;
  logic          dv_q,       dv_d;
  logic [CW-1:0] count_q,    count_d;
  logic          done_q,     done_d;
  logic          ovf_q,      ovf_d;
  logic          und_q,      und_d;

  // ---------------------------------------------------------------------------
  // Edge / event decode
  // ---------------------------------------------------------------------------
  logic sck_rise, sck_fall, lead_edge, trail_edge, cs_fall, cs_rise;
  logic in_frame, sample_edge, shift_edge, frame_start, byte_boundary;
  logic reload, load, shift_ok;
  logic [7:0] rx_next;

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;

  // SCK edges only count while a frame is active and CS_L is still low.
  assign in_frame    = (state_q == ST_ACTIVE) && !cs_s;
  assign sample_edge = in_frame && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = in_frame && (CPHA ? lead_edge : trail_edge);
  assign frame_start = (state_q == ST_IDLE) && cs_fall;

  // CPHA=0: the 8th trailing edge ends a byte. CPHA=1: the first leading edge
  // of every byte after the first fetches the next byte; the very first leading
  // edge only presents bit7, which is already on MISO from frame start.
  assign byte_boundary = shift_edge &&
                         (CPHA ? ((tx_cnt_q == 3'd0) && !first_q) : (tx_cnt_q == 3'd7));
  assign shift_ok      = CPHA ? (tx_cnt_q != 3'd0) : (tx_cnt_q != 3'd7);
  assign reload        = frame_start || byte_boundary;
  assign load          = i_MISO_DV && !hold_full_q;
  assign rx_next       = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    first_d     = first_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_d      = byte_q;
    dv_d        = 1'b0;
    count_d     = count_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    und_d       = und_q;

    case (state_q)
      // Synchronizers come out of reset reading CS_L high; flush_q keeps us
      // here until the chain reflects the real pin, so a frame that was
      // already in progress at reset release is not mistaken for a new one.
      ST_WAIT_HIGH: if (flush_q[1] && cs_s) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          tx_cnt_d   = 3'd0;
          first_d    = 1'b1;
          ovf_d      = 1'b0;
          und_d      = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_WAIT_HIGH;
    endcase

    if (sample_edge) begin
      rx_d      = rx_next;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d     = rx_next;
        dv_d       = 1'b1;
        count_d    = byte_cnt_q;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q == MAX_IDX) ovf_d = 1'b1;
      end
    end

    if (shift_edge) begin
      tx_cnt_d = tx_cnt_q + 3'd1;
      first_d  = 1'b0;
      if (shift_ok) tx_d = {tx_q[6:0], 1'b0};
    end

    if (reload) begin
      if (hold_full_q) begin
        tx_d = hold_q;
      end else begin
        tx_d  = UNDERRUN_BYTE;
        und_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end

    // A load can only happen when empty, so a same-cycle reload has already
    // taken the underrun byte and the new byte simply stays held.
    if (load) begin
      hold_d      = i_MISO_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_HIGH;
      sck_prev_q  <= CPOL;
      cs_prev_q   <= 1'b1;
      flush_q     <= 2'b00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      tx_cnt_q    <= 3'd0;
      first_q     <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      byte_q      <= 8'h00;
      dv_q        <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      flush_q     <= {flush_q[0], 1'b1};
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      count_q     <= count_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      und_q       <= und_d;
    end
  end

  assign o_MOSI_Byte  = byte_q;
  assign o_MOSI_DV    = dv_q;
  assign o_MOSI_Count = count_q;
  assign o_MISO_Ready = ~hold_full_q;
  assign o_Frame_Done = done_q;
  assign o_Overflow   = ovf_q;
  assign o_Underrun   = und_q;

`ifdef SPI_PERIPH_TRISTATE_EN
  assign MISO = (cs_s || (state_q != ST_ACTIVE)) ? 1'bz : tx_q[7];
`else
  assign MISO = (state_q == ST_ACTIVE) ? tx_q[7] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral_cs.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral_cs
//   One peripheral instance per SPI mode; the bench acts as SPI master for the
//   instance selected by cur and compares what it sees against expectations
//   derived from the frame contents (bytes sent, bytes preloaded, bit count).
// -----------------------------------------------------------------------------
module tb_spi_peripheral_cs;

  localparam int MAXB = 2;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int HALF = 4;              // clk cycles per SCK half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  int         cur = 0;
  logic       sck_drv = 1'b0, cs_drv = 1'b1, mosi_drv = 1'b0;
  logic       miso_dv_drv = 1'b0;
  logic [7:0] miso_byte_drv = 8'h00;

  logic [3:0]         sck_w, cs_w, miso_dv_w, miso_w, dv_w, ready_w, done_w, ovf_w, und_w;
  logic [3:0][7:0]    byte_w;
  logic [3:0][CW-1:0] cnt_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam logic POL = (gi >= 2);
    assign sck_w[gi]     = (cur == gi) ? sck_drv : POL;
    assign cs_w[gi]      = (cur == gi) ? cs_drv : 1'b1;
    assign miso_dv_w[gi] = (cur == gi) ? miso_dv_drv : 1'b0;
    spi_peripheral_cs #(
      .SPI_MODE(gi), .MAX_BYTES_PER_CS(MAXB), .UNDERRUN_BYTE(8'hFF)
    ) u_dut (
      .clk(clk), .rst(rst), .SCK(sck_w[gi]), .CS_L(cs_w[gi]), .MOSI(mosi_drv),
      .MISO(miso_w[gi]), .o_MOSI_Byte(byte_w[gi]), .o_MOSI_DV(dv_w[gi]),
      .o_MOSI_Count(cnt_w[gi]), .i_MISO_Byte(miso_byte_drv), .i_MISO_DV(miso_dv_w[gi]),
      .o_MISO_Ready(ready_w[gi]), .o_Frame_Done(done_w[gi]), .o_Overflow(ovf_w[gi]),
      .o_Underrun(und_w[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation of the selected instance
  logic [7:0] dv_bytes[$];
  int         dv_idx[$];
  int         done_cnt = 0;
  logic [7:0] feed[$];

  always @(negedge clk) begin
    if (dv_w[cur]) begin
      dv_bytes.push_back(byte_w[cur]);
      dv_idx.push_back(int'(cnt_w[cur]));
    end
    if (done_w[cur]) done_cnt++;
  end

  // Keeps the holding register topped up from the feed queue
  always @(negedge clk) begin
    if (miso_dv_drv) miso_dv_drv = 1'b0;
    else if (feed.size() > 0 && ready_w[cur]) begin
      miso_byte_drv = feed.pop_front();
      miso_dv_drv   = 1'b1;
    end
  end

  logic [7:0] mosi_tx[8];
  logic [7:0] miso_rx[8];
  logic [7:0] pre[8];

  // Number of bytes the peripheral pulls from the holding register in a frame:
  // one at frame start, then one per byte boundary edge that actually occurs.
  function automatic int fetches(input int mode, input int nfull, input int xbits);
    int nbits = nfull * 8 + xbits;
    if (mode % 2 == 1) return (nbits + 7) / 8;
    return 1 + nfull;
  endfunction

  task automatic drive_bits(input int first, input int nbits);
    logic cpol, cpha;
    cpol = (cur >= 2);
    cpha = (cur % 2 == 1);
    for (int b = first; b < first + nbits; b++) begin
      if (cpha) mosi_drv = mosi_tx[b / 8][7 - b % 8];
      else      miso_rx[b / 8][7 - b % 8] = miso_w[cur];
      sck_drv = ~cpol;
      repeat (HALF) @(negedge clk);
      if (cpha) miso_rx[b / 8][7 - b % 8] = miso_w[cur];
      sck_drv = cpol;
      if (!cpha && b + 1 < 64) mosi_drv = mosi_tx[(b + 1) / 8][7 - (b + 1) % 8];
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int nfull, input int xbits, input int npre);
    int nbits, done0, nf;
    nbits = nfull * 8 + xbits;
    nf    = fetches(cur, nfull, xbits);
    dv_bytes.delete();
    dv_idx.delete();
    sck_drv = (cur >= 2);
    for (int i = 0; i < npre; i++) feed.push_back(pre[i]);
    repeat (4) @(negedge clk);
    done0 = done_cnt;
    cs_drv = 1'b0;
    if (cur % 2 == 0) mosi_drv = mosi_tx[0][7];
    repeat (HALF) @(negedge clk);
    drive_bits(0, nbits);
    cs_drv = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    $display("frame mode=%0d bytes=%0d extra_bits=%0d preload=%0d dv=%0d",
             cur, nfull, xbits, npre, dv_bytes.size());
    check_eq("dv_count", dv_bytes.size(), nfull);
    for (int i = 0; i < nfull && i < dv_bytes.size(); i++) begin
      check_eq($sformatf("mosi_byte%0d", i), dv_bytes[i], mosi_tx[i]);
      check_eq($sformatf("mosi_idx%0d", i), dv_idx[i], i % (1 << CW));
    end
    for (int i = 0; i < nfull; i++)
      check_eq($sformatf("miso_byte%0d", i), miso_rx[i], (i < npre) ? pre[i] : 8'hFF);
    check_eq("frame_done", done_cnt - done0, 1);
    check_eq("overflow", ovf_w[cur], nfull > MAXB);
    check_eq("underrun", und_w[cur], nf > npre);
    check_eq("ready", ready_w[cur], 1'b1);
  endtask

  initial begin
    int nf, nfull, xbits, npre, done0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check_eq($sformatf("rst_miso%0d", m), miso_w[m], 1'b0);
      check_eq($sformatf("rst_ready%0d", m), ready_w[m], 1'b1);
      check_eq($sformatf("rst_flags%0d", m),
               {dv_w[m], done_w[m], ovf_w[m], und_w[m]}, 4'b0000);
      check_eq($sformatf("rst_byte%0d", m), {byte_w[m], 6'(cnt_w[m])}, 14'd0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Fixed two-byte exchange in every mode
    for (int m = 0; m < 4; m++) begin
      cur = m;
      mosi_tx[0] = 8'hA5; mosi_tx[1] = 8'h3C;
      pre[0] = 8'h96; pre[1] = 8'h0F;
      run_frame(2, 0, 2);
    end

    // Underrun on an unloaded single byte
    cur = 0;
    mosi_tx[0] = 8'h55;
    run_frame(1, 0, 0);

    // Overflow on a third byte, then cleared by the next frame
    mosi_tx[0] = 8'h01; mosi_tx[1] = 8'h02; mosi_tx[2] = 8'h03;
    run_frame(3, 0, 0);
    mosi_tx[0] = 8'h7E; pre[0] = 8'h81;
    run_frame(1, 0, 1);

    // Partial byte discarded, following frame unaffected
    mosi_tx[0] = 8'hF0;
    run_frame(0, 5, 0);
    mosi_tx[0] = 8'hC3; pre[0] = 8'h3C;
    run_frame(1, 0, 1);

    // Randomized frames across modes
    for (int t = 0; t < 12; t++) begin
      cur   = $urandom_range(0, 3);
      nfull = $urandom_range(1, 5);
      xbits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      nf    = fetches(cur, nfull, xbits);
      npre  = $urandom_range(0, nf);
      for (int i = 0; i < 8; i++) begin
        mosi_tx[i] = 8'($urandom);
        pre[i]     = 8'($urandom);
      end
      run_frame(nfull, xbits, npre);
    end

    // Reset in the middle of byte 0 with CS_L held low
    cur = 0;
    sck_drv = 1'b0;
    dv_bytes.delete();
    dv_idx.delete();
    mosi_tx[0] = 8'hA5; mosi_tx[1] = 8'h5A;
    repeat (4) @(negedge clk);
    done0 = done_cnt;
    cs_drv = 1'b0;
    mosi_drv = mosi_tx[0][7];
    repeat (HALF) @(negedge clk);
    drive_bits(0, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_bits(3, 13);
    repeat (4) @(negedge clk);
    $display("reset mid-frame: dv=%0d", dv_bytes.size());
    check_eq("rst_mid_no_dv", dv_bytes.size(), 0);
    check_eq("rst_mid_miso", miso_w[0], 1'b0);
    cs_drv = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    check_eq("rst_mid_no_done", done_cnt - done0, 0);
    mosi_tx[0] = 8'hC3; pre[0] = 8'h5A;
    run_frame(1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
